// File: rtl/bp_resolve_ctrl.sv
// In-order branch resolution controller.
// Every prediction issued at fetch is queued here. Each execute-stage
// resolution is matched against the oldest entry. The controller drives the
// predictor update port and raises a one-cycle redirect when the fetch-time
// next PC was wrong. A redirect flushes all younger wrong-path entries and
// spends one cycle in RECOVER before fetch may push again.
module bp_resolve_ctrl #(
    parameter int DEPTH    = 4,
    parameter int PTR_BITS = 2,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                push_valid,
    output logic                push_ready,
    input  logic [31:0]         push_pc,
    input  logic                push_pred_taken,
    input  logic [31:0]         push_pred_next,

    input  logic                resolve_valid,
    input  logic                resolve_taken,
    input  logic [31:0]         resolve_target,

    output logic                update_valid,
    output logic [31:0]         update_pc,
    output logic [31:0]         update_target,
    output logic                update_taken,

    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,

    output logic [PTR_BITS:0]   occupancy,
    output logic                resolve_err,
    output logic [CNT_BITS-1:0] branch_cnt,
    output logic [CNT_BITS-1:0] mispred_cnt
);

    // Controller states; RECOVER lasts exactly one cycle after a redirect.
    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_RECOVER = 1'b1;

    localparam logic [PTR_BITS:0] FULL_COUNT = (PTR_BITS+1)'(DEPTH);

    // Prediction storage, one slot per in-flight branch.
    logic [31:0]         pc_mem        [DEPTH];
    logic                pred_taken_mem[DEPTH];
    logic [31:0]         pred_next_mem [DEPTH];

    logic [PTR_BITS-1:0] head;
    logic [PTR_BITS-1:0] tail;
    logic [PTR_BITS:0]   count;
    logic [0:0]          state;

    logic                full;
    logic                empty;
    logic                resolve_acc;
    logic                push_acc;
    logic                mispredict;
    logic [31:0]         head_pc;
    logic [31:0]         head_pred_next;
    logic [31:0]         actual_next;

    // Queue status and the head entry seen by the resolving branch.
    always_comb begin
        full           = (count == FULL_COUNT);
        empty          = (count == '0);
        head_pc        = pc_mem[head];
        head_pred_next = pred_next_mem[head];
    end

    // Resolve comparison: the fetch-time next PC must match the real one,
    // so a correct direction with a wrong target still counts as a miss.
    always_comb begin
        resolve_acc = resolve_valid && !empty;
        actual_next = resolve_taken ? resolve_target : (head_pc + 32'd4);
        mispredict  = resolve_acc && (actual_next != head_pred_next);
    end

    // Fetch handshake; a same-cycle pop frees a slot, and a push that
    // coincides with a mispredict is wrong-path and silently dropped.
    always_comb begin
        push_ready = reset && (state == ST_RUN) && (!full || resolve_acc);
        push_acc   = push_valid && push_ready && !mispredict;
    end

    // Entry write at the tail; storage needs no reset since occupancy
    // alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            pc_mem[tail]         <= push_pc;
            pred_taken_mem[tail] <= push_pred_taken;
            pred_next_mem[tail]  <= push_pred_next;
        end
    end

    // Pointer, occupancy and state bookkeeping including the flush.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            state <= ST_RUN;
        end else if (mispredict) begin
            head  <= tail;
            count <= '0;
            state <= ST_RECOVER;
        end else begin
            state <= ST_RUN;
            if (push_acc) begin
                tail <= tail + PTR_BITS'(1);
            end
            if (resolve_acc) begin
                head <= head + PTR_BITS'(1);
            end
            count <= count + (PTR_BITS+1)'(push_acc) - (PTR_BITS+1)'(resolve_acc);
        end
    end

    // Registered predictor update and redirect, one cycle after a resolve.
    always_ff @(posedge clk) begin
        if (!reset) begin
            update_valid   <= 1'b0;
            update_pc      <= '0;
            update_target  <= '0;
            update_taken   <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            update_valid   <= resolve_acc;
            redirect_valid <= mispredict;
            if (resolve_acc) begin
                update_pc     <= head_pc;
                update_target <= resolve_target;
                update_taken  <= resolve_taken;
            end
            if (mispredict) begin
                redirect_pc <= actual_next;
            end
        end
    end

    // Saturating statistics and the sticky empty-resolve error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
            resolve_err <= 1'b0;
        end else begin
            if (resolve_acc && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_BITS'(1);
            end
            if (mispredict && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_BITS'(1);
            end
            if (resolve_valid && empty) begin
                resolve_err <= 1'b1;
            end
        end
    end

    assign occupancy = count;

endmodule

// File: doc/bp_resolve_ctrl.md
Name: bp_resolve_ctrl

Overview:
In-order branch resolution controller that sits between fetch, execute and the Gshare predictor. It holds every prediction issued at fetch in a small FIFO. It matches each execute-stage resolution against the oldest entry, drives the predictor's update port and raises a redirect on misprediction. After a redirect it squashes wrong-path entries and runs a one-cycle recovery state.

Parameters:
DEPTH, 4, in-flight prediction entries; power of two, 2..16
PTR_BITS, 2, log2(DEPTH)
CNT_BITS, 16, width of saturating statistics counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
push_valid  in  1  fetch presents a predicted control-flow instruction
push_ready  out  1  entry can be accepted this cycle
push_pc  in  32  PC of predicted instruction
push_pred_taken  in  1  predictor's taken decision
push_pred_next  in  32  next PC chosen at fetch
resolve_valid  in  1  execute resolves the oldest in-flight branch
resolve_taken  in  1  actual direction
resolve_target  in  32  actual taken target
update_valid  out  1  predictor update strobe
update_pc  out  32  predictor update PC
update_target  out  32  predictor update target
update_taken  out  1  predictor update direction
redirect_valid  out  1  one-cycle mispredict pulse
redirect_pc  out  32  correct next PC
occupancy  out  PTR_BITS+1  entries held
resolve_err  out  1  sticky: resolve arrived while queue empty
branch_cnt  out  CNT_BITS  resolved branches, saturating
mispred_cnt  out  CNT_BITS  mispredictions, saturating

Behaviour:
- Reset (reset==0 at posedge):
  - state=RUN, queue empty, pointers 0.
  - All outputs 0, except push_ready=1 once reset releases.
  - Reset overrides every other input in the same cycle.
- Storage: circular FIFO of {pc, pred_taken, pred_next}.
  - Head and tail pointers wrap modulo DEPTH.
  - occupancy ranges 0..DEPTH; full when occupancy==DEPTH.
- States: RUN, RECOVER.
  - RUN: push_ready = !full || resolve accepted this cycle, so a simultaneous pop frees a slot on the same edge.
  - RECOVER: push_ready=0; always returns to RUN on the next cycle.
- Push accept: push_valid && push_ready. The entry is written at tail; tail increments.
- Resolve accept: resolve_valid && occupancy!=0, applied to the head entry.
  - actual_next = resolve_taken ? resolve_target : head.pc+4 (32-bit wrap).
  - mispredict = (actual_next != head.pred_next).
  - A direction match with a wrong target counts as a mispredict.
- Registered outputs, 1-cycle latency from an accepted resolve:
  - update_valid=1; update_pc=head.pc; update_target=resolve_target; update_taken=resolve_taken.
  - branch_cnt increments, saturating at all-ones.
  - On mispredict also: redirect_valid=1, redirect_pc=actual_next, mispred_cnt increments (saturating).
  - The queue is flushed: head=tail, occupancy=0, state->RECOVER.
  - Any push presented in that same cycle is discarded (wrong path).
  - On a correct prediction the head simply pops.
- Pulse outputs: update_valid and redirect_valid are 0 in every cycle not following an accepted resolve.
- Resolve while empty: ignored, no update is issued, resolve_err set and held until reset.
- Simultaneous push+resolve with no mispredict: both take effect; occupancy is unchanged. This is legal even when full.
- RECOVER with a resolve presented: the queue is empty, so it is treated as the empty-resolve error.

Test Plan:
- Reset, then push pc=0x100/pred_taken=0/pred_next=0x104, then resolve taken=0 -> next cycle update_valid=1, update_pc=0x100, update_taken=0, redirect_valid=0, occupancy 1->0, branch_cnt=1.
- Push 0x200 predicted not-taken (pred_next=0x204), resolve taken target=0x400 -> redirect_valid=1, redirect_pc=0x400, mispred_cnt=1, state RECOVER with push_ready=0 for exactly 1 cycle.
- Fill 4 entries (push_ready drops at occupancy=4); push+resolve same cycle while full -> accepted, occupancy stays 4, FIFO order preserved across pointer wrap over 12 ops.
- 3 entries queued, oldest mispredicts while a push is presented -> occupancy=0, the push is dropped, the two younger entries never generate updates.
- Resolve with empty queue -> no update_valid, resolve_err=1 and still 1 after 10 further cycles.
- Predicted taken to 0x300, actual taken to 0x380 -> redirect_pc=0x380; assert reset low mid-stream -> all outputs 0 and occupancy 0 the next cycle.
